// File: rtl/sram_d_arbiter.sv
// rtl/sram_d_arbiter.sv - two-master round-robin OBI arbiter for the SRAM data port
// Out-of-window requests are granted locally and answered with an error response.
module sram_d_arbiter #(
  parameter logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] SRAM_END_ADDR  = 32'h8000_C000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        sram_d_req_o,
  input  logic        sram_d_gnt_i,
  output logic [31:0] sram_d_addr_o,
  output logic        sram_d_we_o,
  output logic [3:0]  sram_d_be_o,
  output logic [31:0] sram_d_wdata_o,
  input  logic        sram_d_rvalid_i,
  input  logic [31:0] sram_d_rdata_i,
  output logic        illegal_access_o,
  output logic        protocol_err_o
);

  logic m0_in_win, m1_in_win;
  logic any_req, win, win_in_win, grant;
  logic prio, pend, owner, lerr;
  logic sram_rsp, rsp_valid;

  assign m0_in_win = (m0_addr_i >= SRAM_BASE_ADDR) && (m0_addr_i < SRAM_END_ADDR);
  assign m1_in_win = (m1_addr_i >= SRAM_BASE_ADDR) && (m1_addr_i < SRAM_END_ADDR);

  // win: 0 selects m0, 1 selects m1; prio only matters when both request
  assign any_req    = m0_req_i | m1_req_i;
  assign win        = (m0_req_i & m1_req_i) ? prio : m1_req_i;
  assign win_in_win = win ? m1_in_win : m0_in_win;

  assign sram_d_req_o     = any_req & win_in_win;
  assign grant            = any_req & (~win_in_win | sram_d_gnt_i);
  assign m0_gnt_o         = grant & ~win;
  assign m1_gnt_o         = grant & win;
  assign illegal_access_o = any_req & ~win_in_win;

  always_comb begin
    sram_d_addr_o  = '0;
    sram_d_we_o    = 1'b0;
    sram_d_be_o    = '0;
    sram_d_wdata_o = '0;
    if (sram_d_req_o) begin
      sram_d_addr_o  = win ? m1_addr_i  : m0_addr_i;
      sram_d_we_o    = win ? m1_we_i    : m0_we_i;
      sram_d_be_o    = win ? m1_be_i    : m0_be_i;
      sram_d_wdata_o = win ? m1_wdata_i : m0_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio           <= 1'b0;
      pend           <= 1'b0;
      owner          <= 1'b0;
      lerr           <= 1'b0;
      protocol_err_o <= 1'b0;
    end else begin
      pend <= grant;
      if (grant) begin
        prio  <= ~win;
        owner <= win;
        lerr  <= ~win_in_win;
      end
      // a response nobody is waiting for from the SRAM is dropped and flagged
      if (sram_d_rvalid_i && (!pend || lerr))
        protocol_err_o <= 1'b1;
    end
  end

  assign sram_rsp  = pend & ~lerr;
  assign rsp_valid = pend & (lerr | sram_d_rvalid_i);

  assign m0_rvalid_o = rsp_valid & ~owner;
  assign m1_rvalid_o = rsp_valid & owner;
  assign m0_rdata_o  = (sram_rsp & ~owner) ? sram_d_rdata_i : '0;
  assign m1_rdata_o  = (sram_rsp & owner) ? sram_d_rdata_i : '0;
  assign m0_err_o    = pend & lerr & ~owner;
  assign m1_err_o    = pend & lerr & owner;

endmodule

// File: doc/sram_d_arbiter.md
# sram_d_arbiter

Two-master OBI arbiter in front of the SRAM wrapper data port (`sram_d_*`). It shares that single read/write port between the core data interface (m0) and a second bus master such as DMA or debug (m1). Arbitration is round-robin, and the arbiter records which master owns each outstanding transfer so the single-cycle SRAM response returns to the correct requester. Requests outside the SRAM window never reach the SRAM; the arbiter completes them locally with an error response.

## Interface
- `SRAM_BASE_ADDR`, default 32'h8000_0000: first legal byte address (inclusive).
- `SRAM_END_ADDR`, default 32'h8000_C000: end of the legal window (exclusive).
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; one clock; reset is asynchronous and active-high.
- `m0_req_i`, `m1_req_i`  in  1  OBI request per master.
- `m0_gnt_o`, `m1_gnt_o`  out  1  OBI grant per master.
- `mX_addr_i`  in  32  byte address, one per master.
- `mX_we_i`  in  1  write enable, one per master.
- `mX_be_i`  in  4  byte enables, one per master.
- `mX_wdata_i`  in  32  write data, one per master.
- `mX_rvalid_o`  out  1  response valid, one per master.
- `mX_rdata_o`  out  32  read data, one per master.
- `mX_err_o`  out  1  error flag qualifying rvalid, one per master.
- `sram_d_req_o`  out  1  request to the SRAM wrapper.
- `sram_d_gnt_i`  in  1  grant from the SRAM wrapper.
- `sram_d_addr_o`  out  32  address to the SRAM wrapper.
- `sram_d_we_o`  out  1  write enable to the SRAM wrapper.
- `sram_d_be_o`  out  4  byte enables to the SRAM wrapper.
- `sram_d_wdata_o`  out  32  write data to the SRAM wrapper.
- `sram_d_rvalid_i`  in  1  response valid from the SRAM wrapper; fixed 1 cycle after its grant.
- `sram_d_rdata_i`  in  32  read data from the SRAM wrapper.
- `illegal_access_o`  out  1  one-cycle pulse when an out-of-window request is granted.
- `protocol_err_o`  out  1  sticky flag: `sram_d_rvalid_i` arrived with no transfer pending.

## Operation
- In-window test: `SRAM_BASE_ADDR <= addr < SRAM_END_ADDR`, using a 32-bit unsigned compare.
- Winner selection each cycle:
  - Only one master requesting: that master wins.
  - Both requesting: the master named by `prio` wins.
  - `prio` is 1 bit; its reset value is 0 (m0).
- In-window winner:
  - `sram_d_req_o`=1, and the winner's addr/we/be/wdata are driven onto `sram_d_*`.
  - `mW_gnt_o = sram_d_gnt_i`.
- Out-of-window winner:
  - `sram_d_req_o`=0.
  - `mW_gnt_o`=1 unconditionally; this is a local grant.
  - `illegal_access_o`=1 in the same cycle.
- No winner: `sram_d_req_o`=0 and all `sram_d_*` payload outputs are 0.
- Loser: `gnt`=0. A master holds its request stable until granted (OBI rule; the arbiter does not latch requests).
- On any grant to master k, `prio` <= the other master. With no grant, `prio` is unchanged. Result: in a back-to-back conflict, neither master waits more than one grant.
- Response tracking registers, loaded on every granted cycle:
  - `pend` <= 1
  - `owner` <= k
  - `lerr` <= out-of-window
  - On a cycle with no grant, `pend` <= 0.
- Response routing, when `pend`=1:
  - `lerr`=0: `m[owner]_rvalid_o = sram_d_rvalid_i`, `rdata = sram_d_rdata_i`, `err`=0.
  - `lerr`=1: `m[owner]_rvalid_o`=1, `rdata`=0, `err`=1. `sram_d_rvalid_i` is not consulted.
- Non-owner master: rvalid=0, rdata=0, err=0.
- If `sram_d_rvalid_i`=1 while `pend`=0, or while `pend`=1 with `lerr`=1:
  - `protocol_err_o` is set and stays set until reset.
  - The stray response is dropped.
- Writes return an rvalid like reads. rdata for a write response is whatever the SRAM wrapper returns and is don't-care to masters.

## Timing
- Request path: request, address and grant are purely combinational (`mX_req_i`/`addr` → `sram_d_req_o`; `sram_d_gnt_i` → `mX_gnt_o`). Zero added latency.
- Response path: a grant at cycle T produces `mX_rvalid_o` at T+1, for both SRAM and local-error responses. rdata passes through combinationally.
- Throughput: one grant per cycle is sustained. The registers for cycle T+1 are overwritten by the grant at T+1, so responses pipeline back to back.
- Reset values: `gnt` and `illegal_access_o` are combinational and are 0 with no requests. Registered state resets to `pend`=0, `owner`=0, `lerr`=0, `prio`=0, `protocol_err_o`=0. Consequently every `mX_rvalid_o`, `mX_err_o` and `mX_rdata_o` is 0 during and after reset until a grant occurs.
- Reset mid-transfer: a transfer granted in the cycle before reset asserts has its response suppressed (`pend` cleared). A late `sram_d_rvalid_i` seen after reset deasserts sets `protocol_err_o`.
- Window edges:
  - addr = `SRAM_END_ADDR`-4 is legal.
  - addr = `SRAM_END_ADDR` is illegal.
  - addr = `SRAM_BASE_ADDR`-1 is illegal.

## Test plan
- m0 alone, read 0x8000_0010 with `sram_d_gnt_i`=1 and rdata 0xCAFE_F00D at T+1 → `m0_gnt_o`=1 at T; `m0_rvalid_o`=1, rdata=0xCAFE_F00D, err=0 at T+1; m1 outputs stay 0.
- m0 and m1 both request for 4 cycles, all in-window → grants go m0, m1, m0, m1; rvalids return to the matching master one cycle after each grant.
- m1 writes 0x8000_C000 → `m1_gnt_o`=1, `sram_d_req_o`=0, `illegal_access_o`=1 at T; `m1_rvalid_o`=1, err=1, rdata=0 at T+1.
- Both request with `sram_d_gnt_i`=0 for 3 cycles, then 1 → no grants and `prio` unchanged while stalled; m0 granted first.
- `sram_d_rvalid_i` pulsed with no request outstanding → `protocol_err_o`=1 and held until `rst_i`; no `mX_rvalid_o` asserted.
- m0 granted at T, `rst_i` asserted at T+1 → no `m0_rvalid_o` at T+1; all registered state at reset values.
